// File: rtl/spi_req_arbiter_if.sv
// Bus bundle between the register-access clients, the request arbiter and the SPI master.
// The slave modport is the arbiter's view; the master modport is the client/SPI-master side.
interface spi_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3
);
  logic [NUM_REQ-1:0]    req_tvalid;
  logic [32*NUM_REQ-1:0] req_tdata;
  logic [NUM_REQ-1:0]    req_tready;
  logic [NUM_REQ-1:0]    resp_tvalid;
  logic [31:0]           resp_tdata;
  logic [NUM_REQ-1:0]    done;
  logic                  resp_err;
  logic                  m_tvalid;
  logic [31:0]           m_tdata;
  logic                  m_tready;
  logic                  s_rx_tvalid;
  logic [31:0]           s_rx_tdata;
  logic                  busy;
  logic [IDX_W-1:0]      cur_grant;

  modport slave (
    input  req_tvalid, req_tdata, m_tready, s_rx_tvalid, s_rx_tdata,
    output req_tready, resp_tvalid, resp_tdata, done, resp_err,
           m_tvalid, m_tdata, busy, cur_grant
  );

  modport master (
    output req_tvalid, req_tdata, m_tready, s_rx_tvalid, s_rx_tdata,
    input  req_tready, resp_tvalid, resp_tdata, done, resp_err,
           m_tvalid, m_tdata, busy, cur_grant
  );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master's 32-bit stream among NUM_REQ clients.
// Optional watchdog on the WAIT states is enabled with `define SPI_ARB_TIMEOUT_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no transfer owned; winner of round-robin is accepted
//   ISSUE   | holding word presented to the SPI master (m_tvalid=1)
//   WAIT_WR | write on the bus; wait for master tready to return
//   WAIT_RD | read on the bus; wait for rx word from the master
//   FINISH  | one-cycle done / resp_tvalid pulse to the owner
module spi_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = 3,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_req_arbiter_if.slave   bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << IDX_W) < NUM_REQ ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("spi_req_arbiter: illegal parameter set");
  end

  localparam int               PAD_W = 1 << IDX_W;
  localparam logic [IDX_W:0]   NUM_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_WR = 3'd2,
    WAIT_RD = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q;
  logic [31:0]        hold_q;
  logic               is_read_q;
  logic               mtv_q;
  logic               busy_q;
  logic [NUM_REQ-1:0] done_q;
  logic [NUM_REQ-1:0] resp_v_q;
  logic [31:0]        resp_d_q;
  logic               err_q;

  logic [PAD_W-1:0]   req_pad;
  logic [IDX_W:0]     cand_sum;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   win;
  logic               win_vld;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] grant_oh;
  logic [31:0]        word_sel;
  logic [NUM_REQ-1:0] rtrdy;
  logic               accept;
  logic               to_hit;
  logic               tmo_hit;

  // Search begins one past the last grant so each client gets a turn.
  always_comb begin
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = bus.req_tvalid;
    cand_sum               = '0;
    cand                   = '0;
    win                    = '0;
    win_vld                = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_sum = {1'b0, last_grant_q} + (IDX_W+1)'(k);
      if (cand_sum >= NUM_W) cand_sum = cand_sum - NUM_W;
      cand = cand_sum[IDX_W-1:0];
      if (!win_vld && req_pad[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  always_comb begin
    win_oh   = '0;
    grant_oh = '0;
    word_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_oh[i]   = win_vld && (win == IDX_W'(i));
      grant_oh[i] = (last_grant_q == IDX_W'(i));
      if (win == IDX_W'(i)) word_sel = bus.req_tdata[32*i +: 32];
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tmo_cnt;

  // Counts cycles spent in either WAIT state; zero on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state_q == WAIT_WR || state_q == WAIT_RD) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = (state_q == WAIT_WR || state_q == WAIT_RD) && (tmo_cnt == TMO_LIM);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    to_hit  = 1'b0;
    rtrdy   = '0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          accept  = 1'b1;
          rtrdy   = win_oh;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mtv_q && bus.m_tready) state_d = is_read_q ? WAIT_RD : WAIT_WR;
      end
      WAIT_WR: begin
        if (bus.m_tready) begin
          state_d = FINISH;
        end else if (tmo_hit) begin
          state_d = FINISH;
          to_hit  = 1'b1;
        end
      end
      WAIT_RD: begin
        if (bus.s_rx_tvalid) begin
          state_d = FINISH;
        end else if (tmo_hit) begin
          state_d = FINISH;
          to_hit  = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= LAST_IDX;
      hold_q       <= '0;
      is_read_q    <= 1'b0;
      mtv_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= '0;
      resp_v_q     <= '0;
      resp_d_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        hold_q       <= word_sel;
        is_read_q    <= word_sel[31];
        last_grant_q <= win;
      end
      mtv_q    <= (state_d == ISSUE);
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == FINISH) ? grant_oh : '0;
      resp_v_q <= (state_d == FINISH && is_read_q && !to_hit) ? grant_oh : '0;
      err_q    <= (state_d == FINISH) && to_hit;
      if (state_q == WAIT_RD && bus.s_rx_tvalid) resp_d_q <= bus.s_rx_tdata;
    end
  end

  assign bus.req_tready  = rtrdy;
  assign bus.resp_tvalid = resp_v_q;
  assign bus.resp_tdata  = resp_d_q;
  assign bus.done        = done_q;
  assign bus.resp_err    = err_q;
  assign bus.m_tvalid    = mtv_q;
  assign bus.m_tdata     = hold_q;
  assign bus.busy        = busy_q;
  assign bus.cur_grant   = last_grant_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter with a small SPI-master model.
// The timeout sequence is built only when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_req_arbiter;
  localparam int NR = 4;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_req_arbiter_if #(.NUM_REQ(NR), .IDX_W(IW)) bus ();

  spi_req_arbiter #(.NUM_REQ(NR), .IDX_W(IW), .TIMEOUT_CYC(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [NR-1:0]    req_tvalid = '0;
  logic [32*NR-1:0] req_tdata  = '0;
  logic             stray_v    = 1'b0;
  int               mdl_delay  = 1;
  logic [31:0]      mdl_rx_data = '0;

  logic       m_rdy;
  logic       mrx_v;
  logic       mrd;
  int         mcnt;

  assign bus.req_tvalid  = req_tvalid;
  assign bus.req_tdata   = req_tdata;
  assign bus.m_tready    = m_rdy;
  assign bus.s_rx_tvalid = mrx_v | stray_v;
  assign bus.s_rx_tdata  = stray_v ? 32'hCAFE_F00D : mdl_rx_data;

  // SPI master model: busy for mdl_delay cycles after a handshake; 0 = never returns.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy <= 1'b1; mcnt <= 0; mrd <= 1'b0; mrx_v <= 1'b0;
    end else begin
      mrx_v <= 1'b0;
      if (m_rdy && bus.m_tvalid) begin
        m_rdy <= 1'b0; mcnt <= mdl_delay; mrd <= bus.m_tdata[31];
      end else if (!m_rdy && mcnt != 0) begin
        if (mcnt == 1) begin
          m_rdy <= 1'b1; mrx_v <= mrd;
        end
        mcnt <= mcnt - 1;
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  logic [31:0] r_mtdata;
  int          r_mt_lat, r_done_lat, r_done_k;
  logic [NR-1:0] r_done, r_rv;
  logic [31:0] r_rd;
  logic        r_err, r_stray_rv, r_ok;

  task automatic do_xfer(input int idx, input logic [31:0] data, input int dly,
                         input logic [31:0] rxd, input int stray_at);
    int trig;
    logic prev_rdy;
    bit got;
    mdl_delay = dly; mdl_rx_data = rxd;
    r_mt_lat = -1; r_done_lat = -1; r_done_k = -1; r_done = '0; r_rv = '0;
    r_rd = '0; r_err = 1'b0; r_stray_rv = 1'b0; r_mtdata = '0; r_ok = 1'b0;
    @(posedge clk); #1;
    req_tvalid[idx] = 1'b1;
    req_tdata[32*idx +: 32] = data;
    got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.req_tready[idx]) begin got = 1; break; end
    end
    if (!got) begin
      chk("accept_wait", 32'd0, 32'd1);
      req_tvalid = '0;
      return;
    end
    @(posedge clk); #1;
    req_tvalid[idx] = 1'b0;
    trig = -1; prev_rdy = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      stray_v = (k == stray_at);
      if (bus.m_tvalid && r_mt_lat < 0) begin r_mt_lat = k; r_mtdata = bus.m_tdata; end
      if (trig < 0 && ((!prev_rdy && m_rdy) || mrx_v)) trig = k;
      prev_rdy = m_rdy;
      if (bus.done != '0) begin
        r_done = bus.done; r_rv = bus.resp_tvalid; r_rd = bus.resp_tdata;
        r_err = bus.resp_err; r_done_k = k; r_done_lat = k - trig; r_ok = 1'b1;
        break;
      end else if (bus.resp_tvalid != '0) begin
        r_stray_rv = 1'b1;
      end
    end
    stray_v = 1'b0;
    if (!r_ok) chk("done_wait", 32'd0, 32'd1);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          dly;
    logic [31:0] rxd;
    int          stray;
    logic [NR-1:0] exp_done;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic [IW-1:0] exp_grant;
  } vec_t;

  vec_t vt[5];

  initial begin
    #500000;
    $display("FAIL global_watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord[8];
    int cnt[NR];
    int n;
    bit multi, idle_ok, quiet;

    vt[0] = '{2, 32'h0012_3456, 40, 32'h0,         0, 4'b0100, 1'b0, 32'h0,         3'd2};
    vt[1] = '{1, 32'h8034_0000, 10, 32'h0000_00A5, 0, 4'b0010, 1'b1, 32'h0000_00A5, 3'd1};
    vt[2] = '{0, 32'h8000_0001, 1,  32'hDEAD_BEEF, 0, 4'b0001, 1'b1, 32'hDEAD_BEEF, 3'd0};
    vt[3] = '{2, 32'h0000_0042, 20, 32'h5A5A_5A5A, 8, 4'b0100, 1'b0, 32'hDEAD_BEEF, 3'd2};
    vt[4] = '{3, 32'h0000_0007, 3,  32'h0,         0, 4'b1000, 1'b0, 32'hDEAD_BEEF, 3'd3};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cur_grant", 32'(bus.cur_grant), 32'd3);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("rst_m_tdata", bus.m_tdata, 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_resp_tvalid", 32'(bus.resp_tvalid), 32'd0);
    chk("rst_resp_tdata", bus.resp_tdata, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      do_xfer(vt[v].idx, vt[v].data, vt[v].dly, vt[v].rxd, vt[v].stray);
      chk($sformatf("v%0d_m_tdata", v), r_mtdata, vt[v].data);
      chk($sformatf("v%0d_m_tvalid_lat", v), 32'(r_mt_lat), 32'd1);
      chk($sformatf("v%0d_done", v), 32'(r_done), 32'(vt[v].exp_done));
      chk($sformatf("v%0d_done_lat", v), 32'(r_done_lat), 32'd1);
      chk($sformatf("v%0d_resp_tvalid", v), 32'(r_rv), vt[v].exp_rv ? 32'(vt[v].exp_done) : 32'd0);
      chk($sformatf("v%0d_resp_tdata", v), r_rd, vt[v].exp_rd);
      chk($sformatf("v%0d_resp_err", v), 32'(r_err), 32'd0);
      chk($sformatf("v%0d_stray_resp", v), 32'(r_stray_rv), 32'd0);
      chk($sformatf("v%0d_cur_grant", v), 32'(bus.cur_grant), 32'(vt[v].exp_grant));
    end

    // Stray rx word while idle
    @(posedge clk); #1; stray_v = 1'b1;
    @(posedge clk); #1; stray_v = 1'b0;
    idle_ok = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.resp_tvalid != '0 || bus.resp_tdata != 32'hDEAD_BEEF || bus.busy) idle_ok = 0;
    end
    chk("idle_stray_rx", 32'(idle_ok), 32'd1);

    // Fairness: all requesters continuously valid
    mdl_delay = 2;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      req_tdata[32*i +: 32] = 32'h0000_0100 + 32'(i);
      cnt[i] = 0;
    end
    req_tvalid = '1;
    n = 0; multi = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.req_tready != '0) begin
        if ($countones(bus.req_tready) != 1) multi = 1;
        for (int i = 0; i < NR; i++) if (bus.req_tready[i]) begin ord[n] = i; cnt[i]++; end
        n++;
      end
      if (n == 8) break;
    end
    @(posedge clk); #1; req_tvalid = '0;
    chk("fair_accepts", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("fair_order_%0d", i), (i < n) ? 32'(ord[i]) : 32'hFFFF_FFFF, 32'(i % NR));
    for (int i = 0; i < NR; i++) chk($sformatf("fair_count_%0d", i), 32'(cnt[i]), 32'd2);
    chk("fair_onehot", 32'(multi), 32'd0);
    idle_ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus.busy) begin idle_ok = 1; break; end
    end
    chk("fair_drain", 32'(idle_ok), 32'd1);

    // Reset pulse in WAIT_RD
    mdl_delay = 50; mdl_rx_data = 32'h1111_2222;
    @(posedge clk); #1;
    req_tvalid[0] = 1'b1; req_tdata[31:0] = 32'h8000_0ABC;
    idle_ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.req_tready[0]) begin idle_ok = 1; break; end
    end
    chk("rrd_accept", 32'(idle_ok), 32'd1);
    @(posedge clk); #1; req_tvalid = '0;
    repeat (5) @(negedge clk);
    chk("rrd_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0; #1;
    chk("rrd_cur_grant", 32'(bus.cur_grant), 32'd3);
    chk("rrd_busy", 32'(bus.busy), 32'd0);
    chk("rrd_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("rrd_m_tdata", bus.m_tdata, 32'd0);
    chk("rrd_done", 32'(bus.done), 32'd0);
    chk("rrd_resp_tvalid", 32'(bus.resp_tvalid), 32'd0);
    chk("rrd_resp_tdata", bus.resp_tdata, 32'd0);
    chk("rrd_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rrd_req_tready", 32'(bus.req_tready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    quiet = 1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.done != '0 || bus.busy || bus.resp_tvalid != '0) quiet = 0;
    end
    chk("rrd_quiet_after", 32'(quiet), 32'd1);
    do_xfer(0, 32'h8000_0ABC, 4, 32'h1111_2222, 0);
    chk("rrd_next_done", 32'(r_done), 32'b0001);
    chk("rrd_next_resp_tvalid", 32'(r_rv), 32'b0001);
    chk("rrd_next_resp_tdata", r_rd, 32'h1111_2222);
    chk("rrd_next_cur_grant", 32'(bus.cur_grant), 32'd0);

`ifdef SPI_ARB_TIMEOUT_EN
    // Read whose rx word never arrives
    do_xfer(1, 32'h8000_1234, 0, 32'h0, 0);
    chk("tmo_done_cycle", 32'(r_done_k), 32'd102);
    chk("tmo_done", 32'(r_done), 32'b0010);
    chk("tmo_resp_err", 32'(r_err), 32'd1);
    chk("tmo_resp_tvalid", 32'(r_rv), 32'd0);
    chk("tmo_resp_tdata", r_rd, 32'h1111_2222);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_req_arbiter.md
# spi_req_arbiter

Round-robin arbiter that lets several register-access clients share the single 4-wire SPI master's 32-bit stream interface. It accepts one word per grant from a requester and forwards it to the master. It then holds the grant until that transfer has finished on the bus, and routes read data back to the owning requester. It sits between the control-plane clients (init sequencer, host register bridge, monitors) and the SPI master.

## Interface
- NUM_REQ, 4, number of requesters; legal 2..8.
- IDX_W, 3, width of grant index; must satisfy 2**IDX_W >= NUM_REQ.
- TIMEOUT_CYC, 65535, watchdog limit in clk cycles; used only with SPI_ARB_TIMEOUT_EN; legal 1..65535.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_tvalid  in  NUM_REQ  per-requester word valid.
- req_tdata  in  32*NUM_REQ  requester i word at [32*i+31:32*i]; bit 31 = 1 means read.
- req_tready  out  NUM_REQ  accept strobe; at most one bit high.
- resp_tvalid  out  NUM_REQ  one-cycle read-data strobe to the owning requester.
- resp_tdata  out  32  read data, shared; valid only with resp_tvalid.
- done  out  NUM_REQ  one-cycle completion strobe for every accepted word.
- resp_err  out  1  qualifies done: transfer aborted by watchdog.
- m_tvalid  out  1  to SPI master tx_tvalid.
- m_tdata  out  32  to SPI master tx_tdata.
- m_tready  in  1  from SPI master tx_tready.
- s_rx_tvalid  in  1  from SPI master rx_tvalid.
- s_rx_tdata  in  32  from SPI master rx_tdata.
- busy  out  1  high in every state except IDLE.
- cur_grant  out  IDX_W  index of the last granted requester.

## Operation
- States: IDLE, ISSUE, WAIT_WR, WAIT_RD, FINISH.
- Round-robin order: search starts at (last_grant+1) mod NUM_REQ and takes the first requester with req_tvalid set. last_grant resets to NUM_REQ-1, so requester 0 wins first.
- IDLE: req_tready[winner] is high combinationally in the same cycle that the winner's req_tvalid is high.
  - On that handshake: capture the word into a holding register and capture is_read = word[31].
  - Update last_grant/cur_grant, then go to ISSUE.
- ISSUE: m_tvalid=1 and m_tdata=holding register.
  - On m_tvalid&&m_tready: go to WAIT_RD if is_read, else WAIT_WR.
- WAIT_WR: on the first cycle with m_tready=1 (the master has returned to idle), go to FINISH.
- WAIT_RD: on s_rx_tvalid, capture s_rx_tdata into resp_tdata and go to FINISH.
- FINISH:
  - done[grant]=1 for one cycle.
  - resp_tvalid[grant]=1 for one cycle if is_read and no timeout occurred.
  - Go to IDLE.
- s_rx_tvalid outside WAIT_RD is ignored.
- req_tready is 0 in every state except IDLE. A requester must hold req_tvalid and its data stable until accepted.
- Reset values:
  - req_tready, resp_tvalid, done: all 0.
  - resp_tdata: 0.
  - resp_err, m_tvalid, busy: 0.
  - m_tdata: 0.
  - cur_grant: NUM_REQ-1.
  - State: IDLE.
- Reset asserted mid-transfer returns the arbiter to IDLE immediately; no done is issued. The SPI master shares rst_n.

## Timing
- Accept cycle T (IDLE handshake), then m_tvalid=1 at T+1.
- Earliest SPI master handshake is at T+1, since the master's tready is high while it is idle.
- Write: done occurs 1 cycle after m_tready re-rises.
- Read: done and resp_tvalid occur 1 cycle after s_rx_tvalid.
- Re-arbitration is back-to-back: IDLE is occupied for one cycle after FINISH. A pending requester is accepted in that cycle, so there are 2 cycles from done to the next m_tvalid.
- With all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transfers.
- All outputs are registered except req_tready.

## Configuration
- SPI_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT_WR or WAIT_RD and increments each cycle spent in those states.
  - When the counter reaches TIMEOUT_CYC-1 without its exit condition, go to FINISH with resp_err=1 and done[grant]=1.
  - In that case resp_tvalid stays 0 and resp_tdata is unchanged.
- SPI_ARB_TIMEOUT_EN undefined: no counter; the WAIT states wait indefinitely; resp_err is tied to 0.

## Test plan
- Single write: req_tvalid[2]=1 with data 32'h0012_3456; the master model raises tready 40 cycles after the handshake.
  - Required: m_tdata=32'h0012_3456, done[2] one cycle after tready, resp_tvalid=0, cur_grant=2.
- Single read: requester 1 sends 32'h8034_0000; the model returns s_rx_tdata=32'h0000_00A5.
  - Required: resp_tvalid[1] and done[1] pulse together with resp_tdata=32'h0000_00A5.
- Fairness: all four requesters are held valid for 8 transfers.
  - Required: grant order 0,1,2,3,0,1,2,3; each req_tready exactly twice.
- Stray s_rx_tvalid during WAIT_WR or IDLE.
  - Required: no resp_tvalid; resp_tdata unchanged.
- Reset pulse during WAIT_RD.
  - Required: all outputs return to their reset values; the next request from requester 0 is granted normally.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYC=100, a read whose model never asserts s_rx_tvalid.
  - Required: done[g]=1 with resp_err=1 on cycle 100 after entering WAIT_RD; resp_tvalid=0.
